// File: rtl/addr_seq3_if.sv
// Handshake/control bundle for the addr_seq3 3-bit decoder address sequencer.
// The dwell field exists only when ADDR_SEQ3_DWELL_EN is defined.
interface addr_seq3_if #(
  parameter int DWELL_W = 4
);
  logic       start;
  logic       stop;
  logic       dir;
  logic       mode;
  logic       load;
  logic [2:0] load_val;
`ifdef ADDR_SEQ3_DWELL_EN
  logic [DWELL_W-1:0] dwell;
`endif
  logic       A2;
  logic       A1;
  logic       A0;
  logic       valid;
  logic       busy;
  logic       done;
  logic       wrap;

  if (DWELL_W < 1) begin : g_dwell_w_check
    $error("addr_seq3_if: DWELL_W must be at least 1");
  end

  modport master (
`ifdef ADDR_SEQ3_DWELL_EN
    output dwell,
`endif
    output start, stop, dir, mode, load, load_val,
    input  A2, A1, A0, valid, busy, done, wrap
  );

  modport slave (
`ifdef ADDR_SEQ3_DWELL_EN
    input  dwell,
`endif
    input  start, stop, dir, mode, load, load_val,
    output A2, A1, A0, valid, busy, done, wrap
  );
endinterface

// File: rtl/addr_seq3.sv
// Up/down, one-shot/continuous address scanner driving a 3-to-8 decoder select.
// Define ADDR_SEQ3_DWELL_EN to hold each address for dwell+1 cycles.
module addr_seq3 #(
  parameter logic [2:0] RESET_ADDR = 3'b000,
  parameter int         DWELL_W    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  addr_seq3_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     r_state;
  logic [2:0] r_addr;
  logic [2:0] r_cnt;
  logic       r_dir;
  logic       r_mode;
  logic       r_valid;
  logic       r_busy;
  logic       r_done;
  logic       r_wrap;

  logic [2:0] w_first;
  logic [2:0] w_next;
  logic       w_wrap;
  logic       w_last;
  logic       w_step;

  if (DWELL_W < 1) begin : g_dwell_w_check
    $error("addr_seq3: DWELL_W must be at least 1");
  end

`ifdef ADDR_SEQ3_DWELL_EN
  logic [DWELL_W-1:0] r_dwell;
  logic [DWELL_W-1:0] r_dcnt;
  assign w_step = (r_dcnt == r_dwell);
`else
  assign w_step = 1'b1;
`endif

  assign w_first = bus.load ? bus.load_val : RESET_ADDR;
  assign w_next  = r_dir ? (r_addr - 3'd1) : (r_addr + 3'd1);
  assign w_wrap  = r_dir ? (r_addr == 3'd0) : (r_addr == 3'd7);
  // r_cnt indexes the address being shown; the eighth one ends a one-shot scan.
  assign w_last  = ~r_mode && (r_cnt == 3'd7);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_addr  <= RESET_ADDR;
      r_cnt   <= 3'd0;
      r_dir   <= 1'b0;
      r_mode  <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_wrap  <= 1'b0;
`ifdef ADDR_SEQ3_DWELL_EN
      r_dwell <= '0;
      r_dcnt  <= '0;
`endif
    end else begin
      // Pulses default low so done/wrap last exactly one cycle.
      r_done <= 1'b0;
      r_wrap <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start && !bus.stop) begin
            r_state <= RUN;
            r_addr  <= w_first;
            r_cnt   <= 3'd0;
            r_dir   <= bus.dir;
            r_mode  <= bus.mode;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
`ifdef ADDR_SEQ3_DWELL_EN
            r_dwell <= bus.dwell;
            r_dcnt  <= '0;
`endif
          end
        end
        RUN: begin
          if (bus.stop) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end else if (w_step) begin
`ifdef ADDR_SEQ3_DWELL_EN
            r_dcnt <= '0;
`endif
            if (w_last) begin
              r_state <= DONE;
              r_valid <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_addr <= w_next;
              r_cnt  <= r_cnt + 3'd1;
              r_wrap <= w_wrap;
            end
          end else begin
`ifdef ADDR_SEQ3_DWELL_EN
            r_dcnt <= r_dcnt + 1'b1;
`endif
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.A2    = r_addr[2];
  assign bus.A1    = r_addr[1];
  assign bus.A0    = r_addr[0];
  assign bus.valid = r_valid;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.wrap  = r_wrap;

endmodule

// File: tb/tb_addr_seq3.sv
// Directed self-checking bench for addr_seq3 (default and ADDR_SEQ3_DWELL_EN builds).
module tb_addr_seq3;
  localparam int DWELL_W = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  addr_seq3_if #(.DWELL_W(DWELL_W)) bus ();

  addr_seq3 #(
    .RESET_ADDR (3'b000),
    .DWELL_W    (DWELL_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  wire [2:0] w_addr = {bus.A2, bus.A1, bus.A0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.dir      = 1'b0;
    bus.mode     = 1'b0;
    bus.load     = 1'b0;
    bus.load_val = 3'd0;
`ifdef ADDR_SEQ3_DWELL_EN
    bus.dwell    = '0;
`endif
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    tick();
    tick();
    total++; if (w_addr !== 3'd0) begin bad++; $display("FAIL reset addr got=%0d want=0", w_addr); end
    total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL reset valid got=%b want=0", bus.valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset busy got=%b want=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset done got=%b want=0", bus.done); end
    total++; if (bus.wrap !== 1'b0) begin bad++; $display("FAIL reset wrap got=%b want=0", bus.wrap); end
    rst_n = 1'b1;
  endtask

  // Start held high through RUN and DONE, dir flipped mid-scan: both must be ignored.
  task automatic test_oneshot_up();
    bus.start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 0) bus.dir = 1'b1;
      total++; if (w_addr !== 3'(i)) begin bad++; $display("FAIL oneshot_up addr[%0d] got=%0d want=%0d", i, w_addr, i); end
      total++; if (bus.valid !== 1'b1) begin bad++; $display("FAIL oneshot_up valid[%0d] got=%b want=1", i, bus.valid); end
      total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL oneshot_up busy[%0d] got=%b want=1", i, bus.busy); end
      total++; if (bus.wrap !== 1'b0) begin bad++; $display("FAIL oneshot_up wrap[%0d] got=%b want=0", i, bus.wrap); end
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL oneshot_up done[%0d] got=%b want=0", i, bus.done); end
    end
    tick();
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL oneshot_up done_pulse got=%b want=1", bus.done); end
    total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL oneshot_up done_valid got=%b want=0", bus.valid); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL oneshot_up done_busy got=%b want=1", bus.busy); end
    bus.start = 1'b0;
    tick();
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL oneshot_up after_done got=%b want=0", bus.done); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL oneshot_up after_busy got=%b want=0", bus.busy); end
    total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL oneshot_up after_valid got=%b want=0", bus.valid); end
    total++; if (w_addr !== 3'd7) begin bad++; $display("FAIL oneshot_up hold_addr got=%0d want=7", w_addr); end
    clear_inputs();
  endtask

  task automatic test_oneshot_down_load();
    logic [2:0] exp_seq [8] = '{3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7, 3'd6};
    bus.start = 1'b1; bus.load = 1'b1; bus.load_val = 3'd5; bus.dir = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 0) begin bus.start = 1'b0; bus.load_val = 3'd1; bus.dir = 1'b0; end
      total++; if (w_addr !== exp_seq[i]) begin bad++; $display("FAIL down_load addr[%0d] got=%0d want=%0d", i, w_addr, exp_seq[i]); end
      total++; if (bus.wrap !== (i == 6)) begin bad++; $display("FAIL down_load wrap[%0d] got=%b want=%b", i, bus.wrap, (i == 6)); end
      total++; if (bus.valid !== 1'b1) begin bad++; $display("FAIL down_load valid[%0d] got=%b want=1", i, bus.valid); end
    end
    tick();
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL down_load done got=%b want=1", bus.done); end
    total++; if (bus.wrap !== 1'b0) begin bad++; $display("FAIL down_load done_wrap got=%b want=0", bus.wrap); end
    tick();
    total++; if (w_addr !== 3'd6) begin bad++; $display("FAIL down_load hold_addr got=%0d want=6", w_addr); end
    clear_inputs();
  endtask

  task automatic test_continuous_stop();
    logic [2:0] exp_addr;
    bus.start = 1'b1; bus.load = 1'b1; bus.load_val = 3'd6; bus.mode = 1'b1;
    for (int i = 0; i < 13; i++) begin
      tick();
      if (i == 0) begin bus.start = 1'b0; bus.load = 1'b0; end
      exp_addr = 3'((6 + i) % 8);
      total++; if (w_addr !== exp_addr) begin bad++; $display("FAIL continuous addr[%0d] got=%0d want=%0d", i, w_addr, exp_addr); end
      total++; if (bus.wrap !== (exp_addr == 3'd0)) begin bad++; $display("FAIL continuous wrap[%0d] got=%b want=%b", i, bus.wrap, (exp_addr == 3'd0)); end
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL continuous done[%0d] got=%b want=0", i, bus.done); end
      total++; if (bus.valid !== 1'b1) begin bad++; $display("FAIL continuous valid[%0d] got=%b want=1", i, bus.valid); end
    end
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL stop valid got=%b want=0", bus.valid); end
    total++; if (w_addr !== 3'd2) begin bad++; $display("FAIL stop addr got=%0d want=2", w_addr); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL stop done got=%b want=0", bus.done); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL stop busy got=%b want=0", bus.busy); end
    tick();
    total++; if (w_addr !== 3'd2) begin bad++; $display("FAIL stop idle_addr got=%0d want=2", w_addr); end
    clear_inputs();
  endtask

  task automatic test_start_stop_conflict();
    bus.start = 1'b1; bus.stop = 1'b1; bus.load = 1'b1; bus.load_val = 3'd4;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL conflict valid[%0d] got=%b want=0", i, bus.valid); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL conflict busy[%0d] got=%b want=0", i, bus.busy); end
      total++; if (w_addr !== 3'd2) begin bad++; $display("FAIL conflict addr[%0d] got=%0d want=2", i, w_addr); end
    end
    clear_inputs();
  endtask

  task automatic test_reset_midscan();
    bus.start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.start = 1'b0;
      total++; if (w_addr !== 3'(i)) begin bad++; $display("FAIL midscan addr[%0d] got=%0d want=%0d", i, w_addr, i); end
    end
    #1 rst_n = 1'b0;
    #1;
    total++; if (w_addr !== 3'd0) begin bad++; $display("FAIL midscan rst_addr got=%0d want=0", w_addr); end
    total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL midscan rst_valid got=%b want=0", bus.valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midscan rst_busy got=%b want=0", bus.busy); end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL midscan post_done[%0d] got=%b want=0", i, bus.done); end
      total++; if (bus.wrap !== 1'b0) begin bad++; $display("FAIL midscan post_wrap[%0d] got=%b want=0", i, bus.wrap); end
      total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL midscan post_valid[%0d] got=%b want=0", i, bus.valid); end
    end
    clear_inputs();
  endtask

`ifdef ADDR_SEQ3_DWELL_EN
  // dwell changed after start must not alter the latched hold time.
  task automatic test_dwell();
    bus.start = 1'b1; bus.dwell = 4'd2;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (i == 0) begin bus.start = 1'b0; bus.dwell = 4'd0; end
      total++; if (w_addr !== 3'(i / 3)) begin bad++; $display("FAIL dwell addr[%0d] got=%0d want=%0d", i, w_addr, i / 3); end
      total++; if (bus.valid !== 1'b1) begin bad++; $display("FAIL dwell valid[%0d] got=%b want=1", i, bus.valid); end
      total++; if (bus.wrap !== 1'b0) begin bad++; $display("FAIL dwell wrap[%0d] got=%b want=0", i, bus.wrap); end
    end
    tick();
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL dwell done got=%b want=1", bus.done); end
    total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL dwell done_valid got=%b want=0", bus.valid); end
    tick();
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL dwell after_done got=%b want=0", bus.done); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL dwell after_busy got=%b want=0", bus.busy); end
    clear_inputs();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_oneshot_up();
    test_oneshot_down_load();
    test_continuous_stop();
    test_start_stop_conflict();
    test_reset_midscan();
`ifdef ADDR_SEQ3_DWELL_EN
    test_dwell();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
